// File: rtl/seq_signed_multiplier_pkg.sv
// Shared types for the sequential add-shift multiplier (package mult_pkg).
// Optional feature macro: MULT_UNSIGNED_MODE_EN (adds Signed_Mode select).
package mult_pkg;

   typedef enum logic [2:0] {IDLE, ADD, SHIFT, DONE, HOLD} mult_state_t;

   // Iteration counter width; must hold WIDTH-1 without wrapping.
   function automatic int count_w(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/seq_signed_multiplier_if.sv
// Handshake/data bundle between the load front end and the multiplier.
// Optional feature macro: MULT_UNSIGNED_MODE_EN (adds Signed_Mode).
interface mult_if #(parameter int WIDTH = 8);
   logic             Start;
   logic             Load_B;
   logic [WIDTH-1:0] Din;
   logic [WIDTH-1:0] S;
`ifdef MULT_UNSIGNED_MODE_EN
   logic             Signed_Mode;
`endif
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Aout;
   logic [WIDTH-1:0] Bout;
   logic             X;

   modport master (
`ifdef MULT_UNSIGNED_MODE_EN
      output Signed_Mode,
`endif
      output Start, Load_B, Din, S,
      input  Busy, Done, Aout, Bout, X
   );

   modport slave (
`ifdef MULT_UNSIGNED_MODE_EN
      input  Signed_Mode,
`endif
      input  Start, Load_B, Din, S,
      output Busy, Done, Aout, Bout, X
   );
endinterface

// File: rtl/seq_signed_multiplier_addsub.sv
// (WIDTH+1)-bit adder/subtractor; operands are sign- or zero-extended by one bit
// so the top bit of the result is the new X (sign in signed mode, carry otherwise).
module mult_addsub #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] s,
   input  logic             sub,
   input  logic             sext,
   output logic [WIDTH:0]   sum
);

   logic [WIDTH:0] a_ext;
   logic [WIDTH:0] s_ext;

   // Extend both operands and add or subtract.
   always_comb begin
      a_ext = {sext & a[WIDTH-1], a};
      s_ext = {sext & s[WIDTH-1], s};
      sum   = sub ? (a_ext - s_ext) : (a_ext + s_ext);
   end

endmodule

// File: rtl/seq_signed_multiplier.sv
// Sequential add-shift multiplier: {A,B} <= S * B over WIDTH add/shift rounds.
// B is kept across runs so a product's low half can be multiplied again.
// Optional feature macro: MULT_UNSIGNED_MODE_EN (Signed_Mode=0 selects unsigned).
//
//   state | meaning
//   IDLE  | waiting; Load_B loads B, Start launches a run
//   ADD   | conditionally add (or subtract on last round) S_reg into {X,A}
//   SHIFT | shift {X,A,B} right by one, advance round counter
//   DONE  | product valid, Done pulses for one cycle
//   HOLD  | result frozen until Start is released
module seq_signed_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic   Clk,
   input logic   Reset_n,
   mult_if.slave bus
);

   localparam int            CW   = count_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   mult_state_t      state, state_nxt;
   logic [WIDTH-1:0] a, b, s_reg;
   logic             x;
   logic [CW-1:0]    count;
   logic             signed_op;
   logic [WIDTH:0]   sum;

`ifdef MULT_UNSIGNED_MODE_EN
   logic signed_reg;

   // Mode is latched with the operands so it cannot change mid-run.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         signed_reg <= 1'b1;
      else if (state == IDLE && !bus.Load_B && bus.Start)
         signed_reg <= bus.Signed_Mode;
   end

   assign signed_op = signed_reg;
`else
   assign signed_op = 1'b1;
`endif

   // The last round carries the negative weight of the multiplier's sign bit.
   mult_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a    (a),
      .s    (s_reg),
      .sub  (signed_op && (count == LAST)),
      .sext (signed_op),
      .sum  (sum)
   );

   // State register.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic; Load_B wins over Start in IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!bus.Load_B && bus.Start) state_nxt = ADD;
         ADD:     state_nxt = SHIFT;
         SHIFT:   state_nxt = (count == LAST) ? DONE : ADD;
         DONE:    state_nxt = HOLD;
         HOLD:    if (!bus.Start) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         a     <= '0;
         b     <= '0;
         x     <= 1'b0;
         s_reg <= '0;
         count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.Load_B) begin
                  b <= bus.Din;
                  a <= '0;
                  x <= 1'b0;
               end else if (bus.Start) begin
                  s_reg <= bus.S;
                  a     <= '0;
                  x     <= 1'b0;
                  count <= '0;
               end
            end
            ADD: begin
               if (b[0])
                  {x, a} <= sum;
            end
            SHIFT: begin
               a <= {x, a[WIDTH-1:1]};
               b <= {a[0], b[WIDTH-1:1]};
               // Unsigned mode shifts the carry in and leaves a clean zero behind.
               x <= signed_op ? x : 1'b0;
               if (count != LAST)
                  count <= count + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.Busy = (state == ADD) || (state == SHIFT) || (state == DONE);
   assign bus.Done = (state == DONE);
   assign bus.Aout = a;
   assign bus.Bout = b;
   assign bus.X    = x;

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Scoreboard bench for seq_signed_multiplier.
module tb_seq_signed_multiplier;
`ifdef MULT_UNSIGNED_MODE_EN
   localparam int W = 16;
`else
   localparam int W = 8;
`endif

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         x;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];
   logic [W-1:0] model_b = '0;

   mult_if #(.WIDTH(W)) bus ();

   seq_signed_multiplier #(.WIDTH(W)) dut (
      .Clk     (clk),
      .Reset_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic push_expect(input logic [W-1:0] s, input logic smode);
      logic [2*W-1:0] p;
      exp_t e;
      if (smode)
         p = {{W{model_b[W-1]}}, model_b} * {{W{s[W-1]}}, s};
      else
         p = {{W{1'b0}}, model_b} * {{W{1'b0}}, s};
      e.a = p[2*W-1:W];
      e.b = p[W-1:0];
      e.x = smode ? p[2*W-1] : 1'b0;
      sb.push_back(e);
      model_b = p[W-1:0];
   endtask

   task automatic do_load(input logic [W-1:0] d);
      @(negedge clk);
      bus.Load_B = 1'b1;
      bus.Din    = d;
      @(negedge clk);
      bus.Load_B = 1'b0;
      model_b    = d;
      checks++;
      if (bus.Aout !== '0 || bus.Bout !== d) begin
         failures++;
         $display("FAIL load: A=%h B=%h expected A=0 B=%h", bus.Aout, bus.Bout, d);
      end
   endtask

   // Launch a run with Start held, wait for Done, compare, optionally hold Start.
   task automatic run_mult(input logic [W-1:0] s, input logic smode,
                           input int hold_n, input bit load_during);
      int   edges = 0;
      int   extra = 0;
      bit   got = 0;
      exp_t e;
      @(negedge clk);
      bus.S     = s;
      bus.Start = 1'b1;
`ifdef MULT_UNSIGNED_MODE_EN
      bus.Signed_Mode = smode;
`endif
      push_expect(s, smode);
      while (!got && edges < 4*W + 10) begin
         @(posedge clk);
         #1;
         edges++;
         if (edges == 1) begin
            checks++;
            if (bus.Busy !== 1'b1) begin
               failures++;
               $display("FAIL busy_start: Busy=%b expected 1", bus.Busy);
            end
         end
         if (load_during && edges == 2) begin
            bus.Load_B = 1'b1;
            bus.Din    = ~model_b;
            bus.S      = ~s;
         end
         if (load_during && edges == 7) bus.Load_B = 1'b0;
         if (bus.Done === 1'b1) begin
            got = 1;
            e = sb.pop_front();
            checks++;
            if (edges != 2*W + 1) begin
               failures++;
               $display("FAIL latency: edges=%0d expected %0d", edges, 2*W + 1);
            end
            checks++;
            if (bus.Aout !== e.a || bus.Bout !== e.b || bus.X !== e.x) begin
               failures++;
               $display("FAIL product: A=%h B=%h X=%b expected A=%h B=%h X=%b",
                        bus.Aout, bus.Bout, bus.X, e.a, e.b, e.x);
            end
         end
      end
      bus.Load_B = 1'b0;
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL timeout: no Done within %0d edges", edges);
         void'(sb.pop_front());
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
         failures++;
         $display("FAIL done_pulse: Done=%b Busy=%b expected 0 0", bus.Done, bus.Busy);
      end
      for (int i = 0; i < hold_n; i++) begin
         @(posedge clk);
         #1;
         if (bus.Done === 1'b1) extra++;
      end
      if (hold_n > 0) begin
         checks++;
         if (extra != 0) begin
            failures++;
            $display("FAIL hold_retrigger: extra_done=%0d expected 0", extra);
         end
      end
      @(negedge clk);
      bus.Start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({bus.Aout, bus.Bout, bus.X, bus.Busy, bus.Done} !== '0) begin
         failures++;
         $display("FAIL reset: A=%h B=%h X=%b Busy=%b Done=%b expected all 0",
                  bus.Aout, bus.Bout, bus.X, bus.Busy, bus.Done);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_priority();
      @(negedge clk);
      bus.Load_B = 1'b1;
      bus.Start  = 1'b1;
      bus.Din    = W'(5);
      @(negedge clk);
      bus.Load_B = 1'b0;
      bus.Start  = 1'b0;
      model_b    = W'(5);
      checks++;
      if (bus.Busy !== 1'b0 || bus.Bout !== W'(5)) begin
         failures++;
         $display("FAIL load_priority: Busy=%b B=%h expected 0 %h", bus.Busy, bus.Bout, W'(5));
      end
   endtask

   task automatic test_basic();
      logic [W-1:0] m3;
      logic [W-1:0] mn;
      m3 = '1 - W'(2);
      mn = '0;
      mn[W-1] = 1'b1;
      do_load(W'(7));
      run_mult(m3, 1'b1, 0, 0);
      do_load(mn);
      run_mult(mn, 1'b1, 0, 0);
      do_load(W'(1));
      run_mult(mn, 1'b1, 0, 0);
   endtask

   task automatic test_back_to_back();
      do_load(W'(2));
      run_mult(W'(3), 1'b1, 0, 0);
      run_mult(W'(3), 1'b1, 0, 0);
   endtask

   task automatic test_hold_and_load();
      do_load(W'(11));
      run_mult('1 - W'(4), 1'b1, 50, 1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 4; i++) begin
         do_load(W'($urandom));
         run_mult(W'($urandom), 1'b1, 0, 0);
      end
   endtask

   task automatic test_mid_reset();
      do_load(W'(9));
      @(negedge clk);
      bus.S     = W'(6);
      bus.Start = 1'b1;
`ifdef MULT_UNSIGNED_MODE_EN
      bus.Signed_Mode = 1'b1;
`endif
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.Aout, bus.Bout, bus.X, bus.Busy, bus.Done} !== '0) begin
         failures++;
         $display("FAIL async_reset: A=%h B=%h X=%b Busy=%b Done=%b expected all 0",
                  bus.Aout, bus.Bout, bus.X, bus.Busy, bus.Done);
      end
      bus.Start = 1'b0;
      model_b   = '0;
      @(negedge clk);
      rst_n = 1'b1;
      do_load('1 - W'(1));
      run_mult(W'(3), 1'b1, 0, 0);
   endtask

`ifdef MULT_UNSIGNED_MODE_EN
   task automatic test_unsigned();
      do_load('1);
      run_mult('1, 1'b0, 0, 0);
      do_load(W'(40000));
      run_mult(W'(50000), 1'b0, 0, 0);
   endtask
`endif

   initial begin
      bus.Start  = 1'b0;
      bus.Load_B = 1'b0;
      bus.Din    = '0;
      bus.S      = '0;
`ifdef MULT_UNSIGNED_MODE_EN
      bus.Signed_Mode = 1'b1;
`endif
      test_reset();
      test_priority();
      test_basic();
      test_back_to_back();
      test_hold_and_load();
      test_random();
      test_mid_reset();
`ifdef MULT_UNSIGNED_MODE_EN
      test_unsigned();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
